// File: rtl/ysyx_23060180_pkg.sv
// Shared types and address helpers for the ysyx_23060180 word memory.
package ysyx_23060180_pkg;

    localparam logic [31:0] MEM_BASE_DEFAULT = 32'h8000_0000;

    typedef enum logic [0:0] {
        MEM_LOAD = 1'b0,
        MEM_RUN  = 1'b1
    } mem_state_t;

    // Word index relative to base; the subtraction wraps deliberately.
    function automatic logic [31:0] mem_idx(input logic [31:0] addr, input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction

    // Misaligned, below base, or past the last word: never wrapped into range.
    function automatic logic mem_addr_bad(input logic [31:0] addr, input logic [31:0] base,
                                          input int unsigned depth);
        logic [31:0] idx_s;
        idx_s = mem_idx(addr, base);
        return (addr[1:0] != 2'b00) || (addr < base) || (idx_s >= depth);
    endfunction

endpackage

// File: rtl/ysyx_23060180_mem_wmerge.sv
// Byte-masked merge: enabled bytes come from wdata, the rest from old_word.
module ysyx_23060180_mem_wmerge
    import ysyx_23060180_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    output logic [31:0] merged
);

    // Per-byte select between new and old data.
    always_comb begin
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (wmask[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_word[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/ysyx_23060180_mem_sram.sv
// Fetch-side word memory with preload stream, byte-masked store and registered reads.
// Optional macro MEM_RAW_BYPASS_EN: same-index read+write returns the merged word.
module ysyx_23060180_mem_sram
    import ysyx_23060180_pkg::*;
#(
    parameter logic [31:0] MEM_BASE    = MEM_BASE_DEFAULT,
    parameter int unsigned DEPTH_WORDS = 4096
)
(
    input  logic        clk,
    input  logic        rstn_in,
    input  logic        ld_valid,
    input  logic        ld_last,
    input  logic [31:0] ld_data,
    output logic        mem_ready,
    input  logic        mem_rd,
    input  logic [31:0] mem_raddr,
    output logic [31:0] mem_rdata,
    output logic        mem_rd_err,
    input  logic        mem_wr,
    input  logic [31:0] mem_waddr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    output logic        mem_wr_err
);

    localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

    mem_state_t     state_r, state_next_s;
    logic [AW-1:0]  ld_cnt_r, ld_cnt_next_s;
    logic [31:0]    mem_r [DEPTH_WORDS];

    logic           rd_bad_s, wr_bad_s, run_wr_s;
    logic [AW-1:0]  ridx_s, widx_s;
    logic [31:0]    rd_old_s, wr_old_s, wr_merged_s, rd_word_s;

    logic           arr_we_s;
    logic [AW-1:0]  arr_widx_s;
    logic [31:0]    arr_wdata_s;

    logic [31:0]    rdata_r;
    logic           rd_err_r, wr_err_r, ready_r;

    // Bad addresses are masked off downstream, so truncated indices stay in range.
    assign rd_bad_s = mem_addr_bad(mem_raddr, MEM_BASE, DEPTH_WORDS);
    assign wr_bad_s = mem_addr_bad(mem_waddr, MEM_BASE, DEPTH_WORDS);
    assign ridx_s   = AW'(mem_idx(mem_raddr, MEM_BASE));
    assign widx_s   = AW'(mem_idx(mem_waddr, MEM_BASE));
    assign rd_old_s = mem_r[ridx_s];
    assign wr_old_s = mem_r[widx_s];
    assign run_wr_s = (state_r == MEM_RUN) && mem_wr && !wr_bad_s;

    ysyx_23060180_mem_wmerge u_wmerge (
        .old_word (wr_old_s),
        .wdata    (mem_wdata),
        .wmask    (mem_wmask),
        .merged   (wr_merged_s)
    );

    // Same-index read data: merged word with bypass, otherwise the pre-write word.
    always_comb begin
`ifdef MEM_RAW_BYPASS_EN
        if (run_wr_s && (ridx_s == widx_s)) begin
            rd_word_s = wr_merged_s;
        end else begin
            rd_word_s = rd_old_s;
        end
`else
        rd_word_s = rd_old_s;
`endif
    end

    // Load/run next-state and preload counter.
    always_comb begin
        state_next_s  = state_r;
        ld_cnt_next_s = ld_cnt_r;
        case (state_r)
            MEM_LOAD: begin
                if (ld_valid) begin
                    ld_cnt_next_s = ld_cnt_r + AW'(1);
                    if (ld_last || (ld_cnt_r == LAST_IDX)) begin
                        state_next_s = MEM_RUN;
                    end else begin
                        state_next_s = MEM_LOAD;
                    end
                end else begin
                    state_next_s = MEM_LOAD;
                end
            end
            MEM_RUN: begin
                state_next_s = MEM_RUN;
            end
            default: begin
                state_next_s  = MEM_LOAD;
                ld_cnt_next_s = '0;
            end
        endcase
    end

    // Single array write port shared by preload (LOAD) and store (RUN).
    always_comb begin
        arr_we_s    = 1'b0;
        arr_widx_s  = ld_cnt_r;
        arr_wdata_s = ld_data;
        if (!rstn_in) begin
            arr_we_s = 1'b0;
        end else if (state_r == MEM_LOAD) begin
            arr_we_s    = ld_valid;
            arr_widx_s  = ld_cnt_r;
            arr_wdata_s = ld_data;
        end else begin
            arr_we_s    = run_wr_s;
            arr_widx_s  = widx_s;
            arr_wdata_s = wr_merged_s;
        end
    end

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (arr_we_s) begin
            mem_r[arr_widx_s] <= arr_wdata_s;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn_in) begin
            state_r  <= MEM_LOAD;
            ld_cnt_r <= '0;
            rdata_r  <= 32'h0;
            rd_err_r <= 1'b0;
            wr_err_r <= 1'b0;
            ready_r  <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            ld_cnt_r <= ld_cnt_next_s;
            ready_r  <= (state_next_s == MEM_RUN);
            if (state_r == MEM_RUN) begin
                if (mem_rd) begin
                    rdata_r  <= rd_bad_s ? 32'h0 : rd_word_s;
                    rd_err_r <= rd_bad_s;
                end else begin
                    rd_err_r <= 1'b0;
                end
                wr_err_r <= mem_wr && wr_bad_s;
            end else begin
                rdata_r  <= 32'h0;
                rd_err_r <= 1'b0;
                wr_err_r <= 1'b0;
            end
        end
    end

    assign mem_ready  = ready_r;
    assign mem_rdata  = rdata_r;
    assign mem_rd_err = rd_err_r;
    assign mem_wr_err = wr_err_r;

endmodule

// File: tb/tb_ysyx_23060180_mem_sram.sv
// Table-driven bench for ysyx_23060180_mem_sram with a result scoreboard (DEPTH_WORDS=8).
module tb_ysyx_23060180_mem_sram;

    localparam int unsigned DEPTH = 8;
`ifdef MEM_RAW_BYPASS_EN
    localparam logic [31:0] RAW_FULL = 32'hFFFF_FFFF;
    localparam logic [31:0] RAW_PART = 32'h0000_A5A5;
`else
    localparam logic [31:0] RAW_FULL = 32'h0000_0000;
    localparam logic [31:0] RAW_PART = 32'h0000_0033;
`endif

    logic        clk = 1'b0;
    logic        rstn_in = 1'b0;
    logic        ld_valid = 1'b0, ld_last = 1'b0;
    logic [31:0] ld_data = 32'h0;
    logic        mem_ready;
    logic        mem_rd = 1'b0;
    logic [31:0] mem_raddr = 32'h0;
    logic [31:0] mem_rdata;
    logic        mem_rd_err;
    logic        mem_wr = 1'b0;
    logic [31:0] mem_waddr = 32'h0, mem_wdata = 32'h0;
    logic [3:0]  mem_wmask = 4'h0;
    logic        mem_wr_err;

    ysyx_23060180_mem_sram #(.MEM_BASE(32'h8000_0000), .DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .rstn_in(rstn_in),
        .ld_valid(ld_valid), .ld_last(ld_last), .ld_data(ld_data),
        .mem_ready(mem_ready),
        .mem_rd(mem_rd), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_rd_err(mem_rd_err),
        .mem_wr(mem_wr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_wr_err(mem_wr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [31:0] raddr;
        logic        wr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] exp_rdata;
        logic        exp_rd_err;
        logic        exp_wr_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        rd_err;
        logic        wr_err;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req) begin
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end else begin
            n_pass++;
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic [31:0] ra, input logic wr,
                                input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] wm,
                                input logic [31:0] er, input logic ere, input logic ewe);
        vec_t v;
        v.rd = rd; v.raddr = ra; v.wr = wr; v.waddr = wa; v.wdata = wd; v.wmask = wm;
        v.exp_rdata = er; v.exp_rd_err = ere; v.exp_wr_err = ewe;
        return v;
    endfunction

    // Drive one cycle of read/write traffic; results are compared one edge later.
    task automatic run_vec(input string name, input vec_t v);
        exp_t e;
        mem_rd = v.rd; mem_raddr = v.raddr;
        mem_wr = v.wr; mem_waddr = v.waddr; mem_wdata = v.wdata; mem_wmask = v.wmask;
        exp_q.push_back('{rdata: v.exp_rdata, rd_err: v.exp_rd_err, wr_err: v.exp_wr_err});
        @(posedge clk);
        #1;
        mem_rd = 1'b0; mem_wr = 1'b0;
        e = exp_q.pop_front();
        chk({name, ".rdata"}, mem_rdata, e.rdata);
        chk({name, ".rd_err"}, {31'h0, mem_rd_err}, {31'h0, e.rd_err});
        chk({name, ".wr_err"}, {31'h0, mem_wr_err}, {31'h0, e.wr_err});
    endtask

    task automatic do_reset(input int cycles);
        rstn_in = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rstn_in = 1'b1;
        chk("rst.ready", {31'h0, mem_ready}, 32'h0);
        chk("rst.rdata", mem_rdata, 32'h0);
        chk("rst.rd_err", {31'h0, mem_rd_err}, 32'h0);
        chk("rst.wr_err", {31'h0, mem_wr_err}, 32'h0);
    endtask

    // One preload word; optionally poke the run ports, which must be ignored in LOAD.
    task automatic ld_word(input logic [31:0] d, input logic last, input logic ready_exp,
                           input logic poke);
        ld_valid = 1'b1; ld_last = last; ld_data = d;
        if (poke) begin
            mem_rd = 1'b1; mem_raddr = 32'h8000_0000;
            mem_wr = 1'b1; mem_waddr = 32'h8000_0004; mem_wdata = 32'hDEAD_BEEF; mem_wmask = 4'hF;
        end
        @(posedge clk);
        #1;
        ld_valid = 1'b0; ld_last = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
        chk("ld.ready", {31'h0, mem_ready}, {31'h0, ready_exp});
        if (poke) begin
            chk("ld.rdata", mem_rdata, 32'h0);
            chk("ld.errs", {30'h0, mem_rd_err, mem_wr_err}, 32'h0);
        end
    endtask

    vec_t vecs[19];
    vec_t post[4];

    initial begin
        vecs[0]  = mk(1'b1, 32'h8000_0008, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0000_0033, 1'b0, 1'b0);
        vecs[1]  = mk(1'b1, 32'h8000_0000, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0000_0011, 1'b0, 1'b0);
        vecs[2]  = mk(1'b1, 32'h8000_0002, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
        vecs[3]  = mk(1'b1, 32'h7FFF_FFFC, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
        vecs[4]  = mk(1'b1, 32'h8000_0020, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
        vecs[5]  = mk(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        vecs[6]  = mk(1'b0, 32'h0, 1'b1, 32'h8000_0000, 32'hAABB_CCDD, 4'hF, 32'h0, 1'b0, 1'b0);
        vecs[7]  = mk(1'b0, 32'h0, 1'b1, 32'h8000_0000, 32'h1122_3344, 4'b0101, 32'h0, 1'b0, 1'b0);
        vecs[8]  = mk(1'b1, 32'h8000_0000, 1'b0, 32'h0, 32'h0, 4'h0, 32'hAA22_CC44, 1'b0, 1'b0);
        vecs[9]  = mk(1'b0, 32'h0, 1'b1, 32'h8000_0020, 32'hDEAD_BEEF, 4'hF, 32'hAA22_CC44, 1'b0, 1'b1);
        vecs[10] = mk(1'b0, 32'h0, 1'b1, 32'h8000_0001, 32'hDEAD_BEEF, 4'hF, 32'hAA22_CC44, 1'b0, 1'b1);
        vecs[11] = mk(1'b1, 32'h8000_0004, 1'b1, 32'h8000_0004, 32'h1234_5678, 4'h0, 32'h0000_0022, 1'b0, 1'b0);
        vecs[12] = mk(1'b0, 32'h0, 1'b1, 32'h8000_001C, 32'hCAFE_F00D, 4'hF, 32'h0000_0022, 1'b0, 1'b0);
        vecs[13] = mk(1'b1, 32'h8000_001C, 1'b0, 32'h0, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 1'b0);
        vecs[14] = mk(1'b0, 32'h0, 1'b1, 32'h8000_0004, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0, 1'b0);
        vecs[15] = mk(1'b1, 32'h8000_0004, 1'b1, 32'h8000_0004, 32'hFFFF_FFFF, 4'hF, RAW_FULL, 1'b0, 1'b0);
        vecs[16] = mk(1'b1, 32'h8000_0004, 1'b0, 32'h0, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        vecs[17] = mk(1'b1, 32'h8000_0008, 1'b1, 32'h8000_0008, 32'hA5A5_A5A5, 4'b0011, RAW_PART, 1'b0, 1'b0);
        vecs[18] = mk(1'b1, 32'h8000_0008, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0000_A5A5, 1'b0, 1'b0);

        post[0] = mk(1'b1, 32'h8000_0000, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0000_0055, 1'b0, 1'b0);
        post[1] = mk(1'b1, 32'h8000_0004, 1'b0, 32'h0, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        post[2] = mk(1'b1, 32'h8000_0008, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0000_A5A5, 1'b0, 1'b0);
        post[3] = mk(1'b1, 32'h8000_001C, 1'b0, 32'h0, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 1'b0);

        // Preload three words with ld_last on the third; run ports poked during LOAD.
        do_reset(2);
        ld_word(32'h0000_0011, 1'b0, 1'b0, 1'b1);
        ld_word(32'h0000_0022, 1'b0, 1'b0, 1'b1);
        ld_word(32'h0000_0033, 1'b1, 1'b1, 1'b1);

        for (int i = 0; i < 19; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // One-cycle reset in RUN, one-word reload, older words must survive.
        do_reset(1);
        ld_word(32'h0000_0055, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_vec($sformatf("post%0d", i), post[i]);
        end

        // Stream past the end with no ld_last: RUN after word DEPTH, extras ignored.
        do_reset(1);
        for (int i = 0; i < DEPTH + 2; i++) begin
            ld_word(32'h0000_0100 + 32'(i), 1'b0, (i >= DEPTH - 1) ? 1'b1 : 1'b0, 1'b0);
        end
        run_vec("fill.last", mk(1'b1, 32'h8000_001C, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0000_0107, 1'b0, 1'b0));
        run_vec("fill.first", mk(1'b1, 32'h8000_0000, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0000_0100, 1'b0, 1'b0));
        run_vec("fill.mid", mk(1'b1, 32'h8000_0008, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0000_0102, 1'b0, 1'b0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
